// File: rtl/light_pkg.sv
// Shared definitions for the light show sequencer.
// - state_e        : sequencer FSM state encoding
// - MODE_*         : pattern-engine mode codes driven on light_mode
// - CLK_HZ_DEFAULT : nominal board clock rate in Hz
// - mode_step()    : next/previous mode with wrap-around
package light_pkg;

  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_AUTO   = 2'd1,
    S_GAP    = 2'd2
  } state_e;

  localparam logic [1:0] MODE_ALT  = 2'd0;
  localparam logic [1:0] MODE_FILL = 2'd1;
  localparam logic [1:0] MODE_SYM  = 2'd2;
  localparam logic [1:0] MODE_RAND = 2'd3;

  localparam int CLK_HZ_DEFAULT = 10;

  // Step the pattern mode one position forward (up=1) or backward (up=0),
  // wrapping at both ends of the four-entry ring.
  function automatic logic [1:0] mode_step(input logic [1:0] mode, input logic up);
    logic [1:0] nxt;
    unique case (mode)
      MODE_ALT:  nxt = up ? MODE_FILL : MODE_RAND;
      MODE_FILL: nxt = up ? MODE_SYM  : MODE_ALT;
      MODE_SYM:  nxt = up ? MODE_RAND : MODE_FILL;
      default:   nxt = up ? MODE_ALT  : MODE_SYM;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Debouncer for one raw, asynchronous, bouncy push button.
// Ports:
//   Clk     - system clock
//   Rst     - synchronous active-high reset, clears every flop
//   btn_raw - raw button level
//   press   - registered one-cycle pulse on each debounced 0->1 transition
// A press appears DEB_CYCLES+3 edges after the first edge that samples the
// button high; glitches shorter than DEB_CYCLES cycles are rejected.
module button_debounce #(
  parameter int DEB_CYCLES = 2
) (
  input  logic Clk,
  input  logic Rst,
  input  logic btn_raw,
  output logic press
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [3:0] cnt_q, cnt_d;
  logic       level_q, level_d;
  logic       level_prev_q, level_prev_d;
  logic       press_q, press_d;

  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    cnt_d        = 4'd0;
    level_d      = level_q;
    level_prev_d = level_q;
    // Count consecutive cycles the synchronised level disagrees with the
    // debounced level; any agreement restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = ~level_q;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
    press_d = level_q & ~level_prev_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= 4'd0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/light_show_sequencer.sv
// Front-end controller for the running-light pattern engine.
// Ports:
//   Clk, Rst         - 10 Hz board clock, synchronous active-high reset
//   btn_next/prev/auto - raw bouncy buttons
//   light_mode       - 2-bit pattern select to the engine
//   blank            - forces the engine's LEDs off after each mode change
//   auto_active      - high while auto-cycling is enabled
//   mode_strobe      - one-cycle pulse on the edge light_mode changes
//   dwell_left       - cycles left before the next auto advance (0 outside S_AUTO)
// All outputs are registered.
module light_show_sequencer
  import light_pkg::*;
#(
  parameter int DEB_CYCLES   = 2,
  parameter int DWELL_CYCLES = 50,
  parameter int GAP_CYCLES   = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_auto,
  output logic [1:0] light_mode,
  output logic       blank,
  output logic       auto_active,
  output logic       mode_strobe,
  output logic [7:0] dwell_left
);

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_CYCLES);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES);

  logic press_next, press_prev, press_auto;

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .Clk     (Clk),
    .Rst     (Rst),
    .btn_raw (btn_next),
    .press   (press_next)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
    .Clk     (Clk),
    .Rst     (Rst),
    .btn_raw (btn_prev),
    .press   (press_prev)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_auto (
    .Clk     (Clk),
    .Rst     (Rst),
    .btn_raw (btn_auto),
    .press   (press_auto)
  );

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic       blank_q, blank_d;
  logic       auto_q, auto_d;
  logic       strobe_q, strobe_d;
  logic [7:0] dwell_q, dwell_d;
  logic [3:0] gap_q, gap_d;
  logic       ret_auto_q, ret_auto_d;

  // Exactly one of next/prev: simultaneous presses cancel out.
  logic       step_req;
  logic [1:0] step_mode;

  assign step_req  = press_next ^ press_prev;
  assign step_mode = mode_step(mode_q, press_next);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    blank_d    = blank_q;
    auto_d     = auto_q;
    strobe_d   = 1'b0;
    dwell_d    = dwell_q;
    gap_d      = gap_q;
    ret_auto_d = ret_auto_q;

    unique case (state_q)
      S_MANUAL: begin
        if (step_req) begin
          // A simultaneous auto press also arms auto-cycling for gap exit.
          mode_d     = step_mode;
          strobe_d   = 1'b1;
          blank_d    = 1'b1;
          gap_d      = GAP_LOAD;
          ret_auto_d = press_auto;
          auto_d     = press_auto;
          dwell_d    = 8'd0;
          state_d    = S_GAP;
        end else if (press_auto) begin
          auto_d  = 1'b1;
          dwell_d = DWELL_LOAD;
          state_d = S_AUTO;
        end
      end

      S_AUTO: begin
        if (step_req) begin
          // Manual step wins over the dwell; an accompanying auto press
          // turns auto-cycling off so the gap returns to S_MANUAL.
          mode_d     = step_mode;
          strobe_d   = 1'b1;
          blank_d    = 1'b1;
          gap_d      = GAP_LOAD;
          ret_auto_d = ~press_auto;
          auto_d     = ~press_auto;
          dwell_d    = 8'd0;
          state_d    = S_GAP;
        end else if (press_auto) begin
          auto_d  = 1'b0;
          dwell_d = 8'd0;
          state_d = S_MANUAL;
        end else if (dwell_q == 8'd1) begin
          mode_d     = mode_step(mode_q, 1'b1);
          strobe_d   = 1'b1;
          blank_d    = 1'b1;
          gap_d      = GAP_LOAD;
          ret_auto_d = 1'b1;
          dwell_d    = 8'd0;
          state_d    = S_GAP;
        end else begin
          dwell_d = dwell_q - 8'd1;
        end
      end

      S_GAP: begin
        // next/prev are dropped here; auto flips where the gap returns to.
        if (press_auto) begin
          ret_auto_d = ~ret_auto_q;
          auto_d     = ~ret_auto_q;
        end
        if (gap_q <= 4'd1) begin
          blank_d = 1'b0;
          gap_d   = 4'd0;
          if (ret_auto_d) begin
            dwell_d = DWELL_LOAD;
            state_d = S_AUTO;
          end else begin
            dwell_d = 8'd0;
            state_d = S_MANUAL;
          end
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end

      default: begin
        state_d = S_MANUAL;
        blank_d = 1'b0;
        auto_d  = 1'b0;
        dwell_d = 8'd0;
        gap_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_MANUAL;
      mode_q     <= MODE_ALT;
      blank_q    <= 1'b0;
      auto_q     <= 1'b0;
      strobe_q   <= 1'b0;
      dwell_q    <= 8'd0;
      gap_q      <= 4'd0;
      ret_auto_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      blank_q    <= blank_d;
      auto_q     <= auto_d;
      strobe_q   <= strobe_d;
      dwell_q    <= dwell_d;
      gap_q      <= gap_d;
      ret_auto_q <= ret_auto_d;
    end
  end

  assign light_mode  = mode_q;
  assign blank       = blank_q;
  assign auto_active = auto_q;
  assign mode_strobe = strobe_q;
  assign dwell_left  = dwell_q;

endmodule

// File: tb/tb_light_show_sequencer.sv
module tb_light_show_sequencer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       btn_auto = 1'b0;
  logic [1:0] light_mode;
  logic       blank;
  logic       auto_active;
  logic       mode_strobe;
  logic [7:0] dwell_left;

  always #5 Clk = ~Clk;

  light_show_sequencer #(
    .DEB_CYCLES   (2),
    .DWELL_CYCLES (4),
    .GAP_CYCLES   (3)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .btn_auto    (btn_auto),
    .light_mode  (light_mode),
    .blank       (blank),
    .auto_active (auto_active),
    .mode_strobe (mode_strobe),
    .dwell_left  (dwell_left)
  );

  // Observed outputs: {light_mode, blank, auto_active, mode_strobe, dwell_left}
  typedef struct packed {
    logic [1:0] mode;
    logic       bl;
    logic       aa;
    logic       stb;
    logic [7:0] dw;
  } obs_t;

  // One run of n cycles with constant inputs {Rst,next,prev,auto} and
  // the outputs expected after every edge of the run.
  typedef struct {
    int         n;
    logic [3:0] in;
    obs_t       exp;
  } vec_t;

  localparam int IDL = 0;
  localparam int AU  = 1;
  localparam int PV  = 2;
  localparam int NX  = 4;
  localparam int RS  = 8;

  vec_t tbl[$];
  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_stb = 1'b0;

  function automatic void add(int n, int inp, int m, int bl, int aa, int stb, int dw);
    vec_t r;
    r.n   = n;
    r.in  = 4'(inp);
    r.exp = {2'(m), 1'(bl), 1'(aa), 1'(stb), 8'(dw)};
    tbl.push_back(r);
  endfunction

  // Manual-mode press: button held 4 cycles, press seen at edge 5, mode
  // change + strobe at edge 6, blank for edges 6..8, then settle.
  function automatic void press_manual(int inp, int old_m, int new_m);
    add(4, inp, old_m, 0, 0, 0, 0);
    add(1, IDL, old_m, 0, 0, 0, 0);
    add(1, IDL, new_m, 1, 0, 1, 0);
    add(2, IDL, new_m, 1, 0, 0, 0);
    add(4, IDL, new_m, 0, 0, 0, 0);
  endfunction

  // mode_strobe must never be high on two consecutive cycles.
  always @(posedge Clk) begin
    #1;
    if (mode_strobe === 1'b1) begin
      checks++;
      if (prev_stb) begin
        errors++;
        $display("FAIL strobe_double t=%0t got strobe=1 twice, required single-cycle pulse", $time);
      end
    end
    prev_stb = (mode_strobe === 1'b1);
  end

  initial begin
    obs_t got;
    obs_t e;
    int   row;
    bit   found;
    int   n_bl;

    // Reset state
    add(2, RS, 0, 0, 0, 0, 0);
    // next held 10 cycles: press at edge 5, change at edge 6, blank 6..8
    add(5, NX, 0, 0, 0, 0, 0);
    add(1, NX, 1, 1, 0, 1, 0);
    add(2, NX, 1, 1, 0, 0, 0);
    add(2, NX, 1, 0, 0, 0, 0);
    add(5, IDL, 1, 0, 0, 0, 0);
    // One-cycle glitch on prev: no press
    add(1, PV, 1, 0, 0, 0, 0);
    add(7, IDL, 1, 0, 0, 0, 0);
    // Clean presses including both wrap directions
    press_manual(PV, 1, 0);
    press_manual(PV, 0, 3);
    press_manual(NX, 3, 0);
    press_manual(NX, 0, 1);
    press_manual(NX, 1, 2);
    // Auto from mode 2, dwell 4: advance to 3, then wrap to 0
    add(4, AU, 2, 0, 0, 0, 0);
    add(1, IDL, 2, 0, 0, 0, 0);
    add(1, IDL, 2, 0, 1, 0, 4);
    add(1, IDL, 2, 0, 1, 0, 3);
    add(1, IDL, 2, 0, 1, 0, 2);
    add(1, IDL, 2, 0, 1, 0, 1);
    add(1, IDL, 3, 1, 1, 1, 0);
    add(2, IDL, 3, 1, 1, 0, 0);
    add(1, IDL, 3, 0, 1, 0, 4);
    add(1, IDL, 3, 0, 1, 0, 3);
    add(1, IDL, 3, 0, 1, 0, 2);
    add(1, IDL, 3, 0, 1, 0, 1);
    add(1, IDL, 0, 1, 1, 1, 0);
    add(2, IDL, 0, 1, 1, 0, 0);
    add(1, IDL, 0, 0, 1, 0, 4);
    // next press lands inside the gap: discarded
    add(1, NX, 0, 0, 1, 0, 3);
    add(1, NX, 0, 0, 1, 0, 2);
    add(1, NX, 0, 0, 1, 0, 1);
    add(1, NX, 1, 1, 1, 1, 0);
    add(2, IDL, 1, 1, 1, 0, 0);
    add(1, IDL, 1, 0, 1, 0, 4);
    add(1, IDL, 1, 0, 1, 0, 3);
    add(1, IDL, 1, 0, 1, 0, 2);
    add(1, IDL, 1, 0, 1, 0, 1);
    // Reset mid-gap in auto, prev held through reset: one press afterwards
    add(1, PV, 2, 1, 1, 1, 0);
    add(1, PV, 2, 1, 1, 0, 0);
    add(2, RS + PV, 0, 0, 0, 0, 0);
    add(5, PV, 0, 0, 0, 0, 0);
    add(1, PV, 3, 1, 0, 1, 0);
    add(2, PV, 3, 1, 0, 0, 0);
    add(2, PV, 3, 0, 0, 0, 0);
    add(8, IDL, 3, 0, 0, 0, 0);
    // next and prev together: no change, no strobe
    add(4, NX + PV, 3, 0, 0, 0, 0);
    add(8, IDL, 3, 0, 0, 0, 0);

    row = 0;
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        @(negedge Clk);
        {Rst, btn_next, btn_prev, btn_auto} = tbl[i].in;
        sb.push_back(tbl[i].exp);
        @(posedge Clk);
        #1;
        got = {light_mode, blank, auto_active, mode_strobe, dwell_left};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL row%0d cyc%0d got mode=%0d blank=%b auto=%b strobe=%b dwell=%0d required mode=%0d blank=%b auto=%b strobe=%b dwell=%0d",
                   i, k, got.mode, got.bl, got.aa, got.stb, got.dw, e.mode, e.bl, e.aa, e.stb, e.dw);
        end
        row++;
      end
    end

    // Hand sequence: auto from mode 3 wraps to mode 0 after the dwell
    @(negedge Clk);
    {Rst, btn_next, btn_prev, btn_auto} = 4'b0001;
    repeat (4) @(negedge Clk);
    btn_auto = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge Clk);
      #1;
      if (mode_strobe === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL auto_strobe_timeout got no strobe in 30 cycles, required one");
    end
    checks++;
    if (light_mode !== 2'd0) begin
      errors++;
      $display("FAIL auto_wrap got mode=%0d required 0", light_mode);
    end
    checks++;
    if (auto_active !== 1'b1) begin
      errors++;
      $display("FAIL auto_flag got %b required 1", auto_active);
    end
    n_bl = 0;
    while (blank === 1'b1 && n_bl < 10) begin
      n_bl++;
      @(posedge Clk);
      #1;
    end
    checks++;
    if (n_bl != 3) begin
      errors++;
      $display("FAIL blank_len got %0d cycles required 3", n_bl);
    end
    checks++;
    if (dwell_left !== 8'd4) begin
      errors++;
      $display("FAIL dwell_reload got %0d required 4", dwell_left);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_show_sequencer.md
Name: light_show_sequencer

Overview:
- Front-end controller that drives the 2-bit `light_mode` select of the board's running-light pattern engine.
- Turns three push buttons (next, prev, auto) into mode changes, and can cycle the four patterns automatically with a fixed dwell time.
- After every mode change it asserts a blanking gap, so the pattern engine restarts from a dark display.
- Runs on the same 10 Hz board clock as the pattern engine and sits between the board buttons and that engine.

Parameters:
- DEB_CYCLES, 2: consecutive cycles a synchronised button level must differ from its debounced level before the debounced level flips (1..15).
- DWELL_CYCLES, 50: cycles each mode is shown in auto mode before advancing (2..255).
- GAP_CYCLES, 3: cycles `blank` is held high after any mode change (1..15).

Ports:
- Clk, input, 1: system clock, 10 Hz.
- Rst, input, 1: reset, synchronous, active-high.
- btn_next, input, 1: raw button, asynchronous, bouncy.
- btn_prev, input, 1: raw button, asynchronous, bouncy.
- btn_auto, input, 1: raw button, asynchronous, bouncy.
- light_mode, output, 2: mode select to the pattern engine.
- blank, output, 1: high means the pattern engine's LEDs are forced off.
- auto_active, output, 1: high while auto-cycling is enabled.
- mode_strobe, output, 1: one-cycle pulse on the edge where `light_mode` changes.
- dwell_left, output, 8: cycles remaining before the next auto advance; 0 when not in S_AUTO.

Behaviour:
- One clock, Clk. Reset is synchronous and active-high on Rst. All outputs are registered.
- Reset values (applied at any Rst edge, including mid-gap or mid-dwell):
  - light_mode = 2'b00, blank = 0, auto_active = 0, mode_strobe = 0, dwell_left = 0.
  - State = S_MANUAL, gap counter = 0.
  - Debouncer synchronisers, counters and debounced levels all cleared to 0.
  - Consequence: a button held through reset yields exactly one press once debounce completes.
- Debounce, per button:
  - 2-flop synchroniser feeds a stability counter.
  - The debounced level flips after DEB_CYCLES consecutive mismatches; any match clears the counter.
  - `press` is a registered 1-cycle pulse on each debounced 0->1 transition.
  - Latency: `press` is high at edge DEB_CYCLES+3, counting the first edge that samples the button high as edge 1.
  - Glitches shorter than DEB_CYCLES cycles produce no press.
- Mode arithmetic:
  - next: `light_mode` + 1, mod 4 (3 -> 0).
  - prev: `light_mode` - 1, mod 4 (0 -> 3).
  - next and prev pressed in the same cycle: no mode change.
- States:
  - S_MANUAL:
    - next or prev press: update `light_mode` on the following edge, pulse `mode_strobe`, load gap counter = GAP_CYCLES, set `blank`, go to S_GAP with ret = MANUAL.
    - auto press: set `auto_active`, load `dwell_left` = DWELL_CYCLES, go to S_AUTO. The mode does not change.
  - S_AUTO:
    - `dwell_left` decrements by 1 each cycle.
    - When `dwell_left` == 1 and no press: advance `light_mode` +1, pulse `mode_strobe`, enter S_GAP with ret = AUTO.
    - next or prev press: apply the step immediately, then enter S_GAP with ret = AUTO. The dwell restarts after the gap.
    - auto press: clear `auto_active`, set `dwell_left` = 0, go to S_MANUAL.
    - auto together with next/prev in one cycle: both take effect; ret = MANUAL.
  - S_GAP:
    - `blank` = 1; the gap counter decrements each cycle.
    - When the counter reaches 1: clear `blank` and go to the ret state. On return to S_AUTO, load `dwell_left` = DWELL_CYCLES.
    - next and prev presses are discarded.
    - An auto press toggles `auto_active` and ret, taking effect at gap exit.
- `blank` duration: exactly GAP_CYCLES cycles after each mode change.
- `mode_strobe` asserts on the same edge that `light_mode` changes and is never high for two consecutive cycles.

Decomposition:
- Shared package light_pkg:
  - state encoding S_MANUAL/S_AUTO/S_GAP as a 2-bit enum-style localparam set.
  - mode constants MODE_ALT = 0, MODE_FILL = 1, MODE_SYM = 2, MODE_RAND = 3.
  - default clock rate constant 10.
- Sub-module button_debounce: synchroniser, stability counter and press pulse, parameterised by DEB_CYCLES. Instantiated three times.
- The FSM and counters live in the top module.

Test Plan:
- Reset, then btn_next held high for 10 cycles (defaults) -> `press` at edge 5, `light_mode` 0 -> 1 and `mode_strobe` = 1 at edge 6, `blank` high for edges 6..8, low from edge 9.
- btn_prev pulsed for 1 cycle (glitch) -> no press, `light_mode` unchanged; a clean btn_prev press from mode 0 -> `light_mode` = 3.
- Auto press with DWELL_CYCLES = 4 from mode 2 -> `dwell_left` sequence 4, 3, 2, 1, then `light_mode` = 3 with a 3-cycle blank, then mode 0 after the next dwell (wrap).
- Next press during S_GAP -> ignored; btn_next and btn_prev debounced in the same cycle -> no change, no strobe.
- Rst asserted mid-gap in S_AUTO -> next edge: `light_mode` = 0, `blank` = 0, `auto_active` = 0, `dwell_left` = 0; a button held through reset -> exactly one press after release from reset.
